// File: rtl/data_mem_access_unit.sv
// Data-memory access unit for the MEM stage: decodes loads/stores, drives a req/ack memory port, extends load data.
// Latency: 3 cycles minimum (IDLE decode, ACCESS until MEM_ACK, DONE); each extra ACCESS cycle adds one.
// Backpressure: BUSYWAIT stalls the pipeline from op decode until MEM_ACK; memory backpressures by delaying MEM_ACK.
// Ports: CLK/RESET (sync, active-high); READ_WRITE/ADDRESS/DATA2 from EX/MEM; BUSYWAIT/LOAD_DATA/MISALIGNED to
//        pipeline; MEM_REQ/MEM_WE/MEM_ADDRESS/MEM_WRITEDATA/MEM_BYTE_EN out to memory, MEM_READDATA/MEM_ACK back.
module data_mem_access_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  READ_WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] DATA2,
    output logic        BUSYWAIT,
    output logic [31:0] LOAD_DATA,
    output logic        MISALIGNED,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    output logic [3:0]  MEM_BYTE_EN,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_ACK
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;
    logic [3:0]  mem_byte_en_q, mem_byte_en_d;
    logic [31:0] load_data_q, load_data_d;
    logic        misaligned_q, misaligned_d;
    // Access shape captured at IDLE exit so load extension does not depend on the (stalled) op inputs.
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [1:0]  addr_lo_q, addr_lo_d;

    logic        is_load, is_store, is_unsigned, aligned, start;
    logic [1:0]  size;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_unsigned = 1'b0;
        size        = SZ_BYTE;
        case (READ_WRITE)
            4'b0110: begin is_store = 1'b1; size = SZ_WORD; end
            4'b0101: begin is_store = 1'b1; size = SZ_HALF; end
            4'b0100: begin is_store = 1'b1; size = SZ_BYTE; end
            4'b1010: begin is_load  = 1'b1; size = SZ_WORD; end
            4'b1001: begin is_load  = 1'b1; size = SZ_HALF; end
            4'b1000: begin is_load  = 1'b1; size = SZ_BYTE; end
            4'b1101: begin is_load  = 1'b1; size = SZ_HALF; is_unsigned = 1'b1; end
            4'b1100: begin is_load  = 1'b1; size = SZ_BYTE; is_unsigned = 1'b1; end
            default: ;
        endcase

        case (size)
            SZ_WORD: aligned = (ADDRESS[1:0] == 2'b00);
            SZ_HALF: aligned = ~ADDRESS[0];
            default: aligned = 1'b1;
        endcase

        // Only IDLE may launch an access: in DONE the stalled op is still presented and must not re-issue.
        start = (state_q == IDLE) && (is_load || is_store) && aligned;

        case (addr_lo_q)
            2'd0:    rd_byte = MEM_READDATA[7:0];
            2'd1:    rd_byte = MEM_READDATA[15:8];
            2'd2:    rd_byte = MEM_READDATA[23:16];
            default: rd_byte = MEM_READDATA[31:24];
        endcase
        rd_half = addr_lo_q[1] ? MEM_READDATA[31:16] : MEM_READDATA[15:0];

        state_d         = state_q;
        mem_we_d        = mem_we_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        mem_byte_en_d   = mem_byte_en_q;
        load_data_d     = load_data_q;
        size_d          = size_q;
        unsigned_d      = unsigned_q;
        addr_lo_d       = addr_lo_q;
        misaligned_d    = (state_q == IDLE) && (is_load || is_store) && !aligned;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = ACCESS;
                    mem_we_d      = is_store;
                    mem_address_d = {ADDRESS[31:2], 2'b00};
                    size_d        = size;
                    unsigned_d    = is_unsigned;
                    addr_lo_d     = ADDRESS[1:0];
                    if (is_store) begin
                        case (size)
                            SZ_WORD: begin
                                mem_writedata_d = DATA2;
                                mem_byte_en_d   = 4'b1111;
                            end
                            SZ_HALF: begin
                                mem_writedata_d = {2{DATA2[15:0]}};
                                mem_byte_en_d   = ADDRESS[1] ? 4'b1100 : 4'b0011;
                            end
                            default: begin
                                mem_writedata_d = {4{DATA2[7:0]}};
                                mem_byte_en_d   = 4'b0001 << ADDRESS[1:0];
                            end
                        endcase
                    end else begin
                        mem_writedata_d = 32'h0;
                        mem_byte_en_d   = 4'b0000;
                    end
                end
            end
            ACCESS: begin
                if (MEM_ACK) begin
                    state_d = DONE;
                    if (!mem_we_q) begin
                        case (size_q)
                            SZ_WORD: load_data_d = MEM_READDATA;
                            SZ_HALF: load_data_d = unsigned_q ? {16'h0, rd_half}
                                                              : {{16{rd_half[15]}}, rd_half};
                            default: load_data_d = unsigned_q ? {24'h0, rd_byte}
                                                              : {{24{rd_byte[7]}}, rd_byte};
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        mem_req_d = (state_d == ACCESS);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= IDLE;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_address_q   <= 32'h0;
            mem_writedata_q <= 32'h0;
            mem_byte_en_q   <= 4'b0000;
            load_data_q     <= 32'h0;
            misaligned_q    <= 1'b0;
            size_q          <= SZ_BYTE;
            unsigned_q      <= 1'b0;
            addr_lo_q       <= 2'b00;
        end else begin
            state_q         <= state_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            mem_byte_en_q   <= mem_byte_en_d;
            load_data_q     <= load_data_d;
            misaligned_q    <= misaligned_d;
            size_q          <= size_d;
            unsigned_q      <= unsigned_d;
            addr_lo_q       <= addr_lo_d;
        end
    end

    assign BUSYWAIT      = !RESET && (start || (state_q == ACCESS));
    assign MEM_REQ       = mem_req_q;
    assign MEM_WE        = mem_we_q;
    assign MEM_ADDRESS   = mem_address_q;
    assign MEM_WRITEDATA = mem_writedata_q;
    assign MEM_BYTE_EN   = mem_byte_en_q;
    assign LOAD_DATA     = load_data_q;
    assign MISALIGNED    = misaligned_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench for data_mem_access_unit: stimulus pushes expected memory requests, load results and
// misaligned flags into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_data_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  READ_WRITE;
    logic [31:0] ADDRESS, DATA2, MEM_READDATA;
    logic        MEM_ACK;
    logic        BUSYWAIT, MISALIGNED, MEM_REQ, MEM_WE;
    logic [31:0] LOAD_DATA, MEM_ADDRESS, MEM_WRITEDATA;
    logic [3:0]  MEM_BYTE_EN;

    data_mem_access_unit dut (
        .CLK(CLK), .RESET(RESET), .READ_WRITE(READ_WRITE), .ADDRESS(ADDRESS), .DATA2(DATA2),
        .BUSYWAIT(BUSYWAIT), .LOAD_DATA(LOAD_DATA), .MISALIGNED(MISALIGNED), .MEM_REQ(MEM_REQ),
        .MEM_WE(MEM_WE), .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_BYTE_EN(MEM_BYTE_EN), .MEM_READDATA(MEM_READDATA), .MEM_ACK(MEM_ACK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_load[$];
    int          exp_mis[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_load = 32'h0;
    logic        ack_seen = 1'b0;

    localparam logic [3:0] NOP = 4'b0000, SW = 4'b0110, SH = 4'b0101, SB = 4'b0100;
    localparam logic [3:0] LW = 4'b1010, LH = 4'b1001, LB = 4'b1000, LHU = 4'b1101, LBU = 4'b1100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: a completed handshake is compared against the oldest expected request;
    // the cycle after it (DONE) LOAD_DATA is compared against the expected load result.
    always @(negedge CLK) begin
        if (ack_seen) begin
            ack_seen = 1'b0;
            if (exp_load.size() == 0) chk("load_q_underflow", 32'h1, 32'h0);
            else chk("load_data_done", LOAD_DATA, exp_load.pop_front());
        end
        if (!RESET && MEM_REQ && MEM_ACK) begin
            if (exp_req.size() == 0) chk("req_q_underflow", 32'h1, 32'h0);
            else begin
                req_t e;
                e = exp_req.pop_front();
                chk("mem_we", {31'h0, MEM_WE}, {31'h0, e.we});
                chk("mem_address", MEM_ADDRESS, e.addr);
                chk("mem_byte_en", {28'h0, MEM_BYTE_EN}, {28'h0, e.be});
                if (e.we) chk("mem_writedata", MEM_WRITEDATA, e.wdata);
            end
            ack_seen = 1'b1;
        end
        if (MISALIGNED === 1'b1) begin
            if (exp_mis.size() == 0) chk("misaligned_unexpected", 32'h1, 32'h0);
            else void'(exp_mis.pop_front());
        end
    end

    // Valid aligned op: ACK on the n-th ACCESS cycle, op held through DONE.
    task automatic do_op(input logic [3:0] rw, input logic [31:0] addr, input logic [31:0] d2,
                         input logic [31:0] rdata, input int n, input req_t e, input logic [31:0] ld);
        int busy_cnt;
        exp_req.push_back(e);
        if (!e.we) last_load = ld;
        exp_load.push_back(last_load);
        READ_WRITE = rw; ADDRESS = addr; DATA2 = d2;
        busy_cnt = 0;
        @(negedge CLK);
        if (BUSYWAIT) busy_cnt++;
        chk("mem_req_idle", {31'h0, MEM_REQ}, 32'h0);
        @(posedge CLK); #1;
        for (int k = 1; k <= n; k++) begin
            if (k == n) begin MEM_ACK = 1'b1; MEM_READDATA = rdata; end
            @(negedge CLK);
            if (BUSYWAIT) busy_cnt++;
            chk("mem_req_access", {31'h0, MEM_REQ}, 32'h1);
            @(posedge CLK); #1;
            MEM_ACK = 1'b0; MEM_READDATA = 32'h5A5A5A5A;
        end
        @(negedge CLK);
        chk("busywait_done", {31'h0, BUSYWAIT}, 32'h0);
        chk("mem_req_done", {31'h0, MEM_REQ}, 32'h0);
        chk("busywait_cycles", busy_cnt, n + 1);
        @(posedge CLK); #1;
        READ_WRITE = NOP;
        @(negedge CLK);
        chk("mem_req_after_done", {31'h0, MEM_REQ}, 32'h0);
        @(posedge CLK); #1;
    endtask

    task automatic do_misaligned(input logic [3:0] rw, input logic [31:0] addr);
        exp_mis.push_back(1);
        READ_WRITE = rw; ADDRESS = addr; DATA2 = 32'hFFFFFFFF;
        @(negedge CLK);
        chk("mis_busywait", {31'h0, BUSYWAIT}, 32'h0);
        chk("mis_mem_req", {31'h0, MEM_REQ}, 32'h0);
        @(posedge CLK); #1;
        READ_WRITE = NOP;
        @(negedge CLK);
        chk("mis_mem_req_next", {31'h0, MEM_REQ}, 32'h0);
        chk("mis_load_data", LOAD_DATA, last_load);
        @(posedge CLK); #1;
    endtask

    function automatic req_t mk(input logic we, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        req_t r;
        r.we = we; r.addr = a; r.wdata = w; r.be = be;
        return r;
    endfunction

    initial begin
        // Reset with a live load and ACK presented: everything must stay quiet.
        RESET = 1'b1; READ_WRITE = LW; ADDRESS = 32'h100; DATA2 = 32'h0;
        MEM_ACK = 1'b1; MEM_READDATA = 32'h12345678;
        @(posedge CLK); @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst_busywait", {31'h0, BUSYWAIT}, 32'h0);
        chk("rst_mem_req", {31'h0, MEM_REQ}, 32'h0);
        chk("rst_mem_we", {31'h0, MEM_WE}, 32'h0);
        chk("rst_mem_address", MEM_ADDRESS, 32'h0);
        chk("rst_mem_writedata", MEM_WRITEDATA, 32'h0);
        chk("rst_mem_byte_en", {28'h0, MEM_BYTE_EN}, 32'h0);
        chk("rst_load_data", LOAD_DATA, 32'h0);
        chk("rst_misaligned", {31'h0, MISALIGNED}, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b0; READ_WRITE = NOP; MEM_ACK = 1'b0;
        @(posedge CLK); #1;

        do_op(LW,  32'h100, 32'h0, 32'hDEADBEEF, 2, mk(1'b0, 32'h100, 32'h0, 4'b0000), 32'hDEADBEEF);
        do_op(LB,  32'h103, 32'h0, 32'h80FF1234, 1, mk(1'b0, 32'h100, 32'h0, 4'b0000), 32'hFFFFFF80);
        do_op(LBU, 32'h103, 32'h0, 32'h80FF1234, 1, mk(1'b0, 32'h100, 32'h0, 4'b0000), 32'h00000080);
        do_op(SB,  32'h202, 32'h123456AB, 32'h0, 1, mk(1'b1, 32'h200, 32'hABABABAB, 4'b0100), 32'h0);
        do_misaligned(LH, 32'h101);
        do_op(SW,  32'h300, 32'hCAFEF00D, 32'h0, 3, mk(1'b1, 32'h300, 32'hCAFEF00D, 4'b1111), 32'h0);
        do_op(SH,  32'h306, 32'h0000BEEF, 32'h0, 1, mk(1'b1, 32'h304, 32'hBEEFBEEF, 4'b1100), 32'h0);
        do_op(SH,  32'h308, 32'h99991234, 32'h0, 1, mk(1'b1, 32'h308, 32'h12341234, 4'b0011), 32'h0);
        do_op(LH,  32'h102, 32'h0, 32'h80017FFF, 2, mk(1'b0, 32'h100, 32'h0, 4'b0000), 32'hFFFF8001);
        do_op(LHU, 32'h102, 32'h0, 32'h80017FFF, 1, mk(1'b0, 32'h100, 32'h0, 4'b0000), 32'h00008001);
        do_op(LH,  32'h100, 32'h0, 32'h12347FFF, 1, mk(1'b0, 32'h100, 32'h0, 4'b0000), 32'h00007FFF);
        do_op(LB,  32'h101, 32'h0, 32'h00007F00, 1, mk(1'b0, 32'h100, 32'h0, 4'b0000), 32'h0000007F);
        do_misaligned(LW, 32'h102);
        do_misaligned(SW, 32'h001);
        do_misaligned(LHU, 32'h003);
        do_op(SB,  32'h001, 32'h00000055, 32'h0, 1, mk(1'b1, 32'h000, 32'h55555555, 4'b0010), 32'h0);

        // Undefined code with a stray ACK: no request, no stall, LOAD_DATA untouched.
        READ_WRITE = 4'b0111; ADDRESS = 32'h400; MEM_ACK = 1'b1; MEM_READDATA = 32'h11111111;
        @(negedge CLK);
        chk("nop_busywait", {31'h0, BUSYWAIT}, 32'h0);
        chk("nop_mem_req", {31'h0, MEM_REQ}, 32'h0);
        @(posedge CLK); #1;
        MEM_ACK = 1'b0; READ_WRITE = NOP;
        @(negedge CLK);
        chk("stray_ack_load_data", LOAD_DATA, last_load);
        chk("nop_mem_req_next", {31'h0, MEM_REQ}, 32'h0);
        @(posedge CLK); #1;

        // Reset in the middle of an ACCESS with ACK in the same cycle.
        READ_WRITE = LW; ADDRESS = 32'h400;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("pre_rst_mem_req", {31'h0, MEM_REQ}, 32'h1);
        @(posedge CLK); #1;
        RESET = 1'b1; MEM_ACK = 1'b1; MEM_READDATA = 32'h11111111;
        @(negedge CLK);
        chk("rst_access_busywait", {31'h0, BUSYWAIT}, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b0; MEM_ACK = 1'b0; READ_WRITE = NOP;
        last_load = 32'h0;
        @(negedge CLK);
        chk("post_rst_mem_req", {31'h0, MEM_REQ}, 32'h0);
        chk("post_rst_load_data", LOAD_DATA, 32'h0);
        chk("post_rst_mem_address", MEM_ADDRESS, 32'h0);
        chk("post_rst_busywait", {31'h0, BUSYWAIT}, 32'h0);
        @(posedge CLK); #1;

        // A load after the abandoned access works normally.
        do_op(LBU, 32'h402, 32'h0, 32'h00C30000, 1, mk(1'b0, 32'h400, 32'h0, 4'b0000), 32'h000000C3);

        repeat (2) @(posedge CLK);
        #1;
        chk("req_q_drained", exp_req.size(), 0);
        chk("load_q_drained", exp_load.size(), 0);
        chk("mis_q_drained", exp_mis.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
